// File: rtl/decoder24_hold.sv
// decoder24_hold: registered 2-to-4 decoder that holds the decoded one-hot
// line for HOLD clock cycles, then pulses done for one cycle.
//
// Ports:
//   clk   - system clock, rising edge
//   rst   - asynchronous active-high reset
//   en    - code valid, sampled only while idle
//   x, y  - 2-bit code {x,y}
//   a..d  - registered one-hot decoded lines for codes 00, 01, 10, 11
//   busy  - high while a line is being held; en is ignored meanwhile
//   done  - one-cycle pulse on the cycle after the hold ends
//
// HOLD must be in 1..255 and 2**CNT_W must exceed HOLD-1.
module decoder24_hold #(
  parameter int unsigned HOLD  = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic x,
  input  logic y,
  output logic a,
  output logic b,
  output logic c,
  output logic d,
  output logic busy,
  output logic done
);

  typedef enum logic {
    IDLE    = 1'b0,
    HOLDING = 1'b1
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;

  // Single registered FSM; every output is a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      a     <= 1'b0;
      b     <= 1'b0;
      c     <= 1'b0;
      d     <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // done only survives the single cycle spent here after a hold.
          done <= 1'b0;
          if (en) begin
            a     <= ~x & ~y;
            b     <= ~x &  y;
            c     <=  x & ~y;
            d     <=  x &  y;
            busy  <= 1'b1;
            // The load cycle counts as the first held cycle.
            cnt   <= CNT_W'(HOLD - 1);
            state <= HOLDING;
          end
        end
        HOLDING: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            a     <= 1'b0;
            b     <= 1'b0;
            c     <= 1'b0;
            d     <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule
